sigma_delta_dac: RTL
====================

// Module: sigma_delta_dac
// PURPOSE
//  First-order sigma-delta modulator. Turns a stream of signed PCM samples into a 1-bit pulse-density stream.
//  An external RC network, or the on-chip lowpass integrator, reconstructs the analog or PCM value from that stream.
//  Audio/DSP path on GateMate, driven by the same clock/enable sampling scheme as the filter chain.
// PARAMETERS
//  BITS_IN   12  signed input sample width; modulator accumulator is BITS_IN+1 bits
//  OSR_LOG2  4   oversampling ratio 2^OSR_LOG2: enable ticks per PCM sample period
// PORTS
//  clock       in   1        single clock, rising edge
//  reset_n     in   1        asynchronous, active-low reset
//  enable      in   1        modulator step tick (sets the bitstream rate)
//  in_valid    in   1        data_in holds a sample
//  in_ready    out  1        1-entry holding buffer is empty
//  data_in     in   BITS_IN  signed two's-complement sample
//  dac_out     out  1        registered pulse-density output
//  underrun    out  1        1-clock pulse: period boundary reached with no new sample
//  running     out  1        high once the first sample has been loaded
// BEHAVIOUR
//  Reset values (async, reset_n=0):
//   - acc=0, dac_out=0, tick_cnt=0, active=0, buffer empty, in_ready=1, underrun=0, running=0.
//  Handshake:
//   - A sample is accepted when in_valid && in_ready.
//   - in_ready = ~buf_full, registered.
//   - in_valid may stay high across cycles; a sample is never accepted twice.
//  Sample period:
//   - tick_cnt counts enable ticks, mod 2^OSR_LOG2.
//   - Boundary = enable && tick_cnt==2^OSR_LOG2-1.
//  At a boundary:
//   - buffer full -> active<=buffer, buffer empties; in_ready=1 next cycle.
//   - buffer empty with a same-cycle handshake -> active<=data_in directly, buffer stays empty, no underrun.
//   - buffer empty, no handshake -> active is held, underrun=1 for that single clock.
//   - Underrun is suppressed while running=0.
//  State: IDLE (running=0) -> RUN on the first boundary load. RUN -> IDLE only via reset.
//  Modulator step, on each enable; idle clocks hold all state:
//   - u = active + 2^(BITS_IN-1), offset binary, unsigned BITS_IN bits.
//   - s = acc[BITS_IN-1:0] + u (+ dither bit); acc<=s; dac_out<=s[BITS_IN].
//   - Ones density = u/2^BITS_IN.
//   - Latency: dac_out updates 1 clock after the enable tick.
//   - A new active sample affects the step at the tick after the boundary.
//  Boundaries:
//   - active = -2^(BITS_IN-1) -> dac_out constant 0.
//   - active = 2^(BITS_IN-1)-1 -> one 0 per 2^BITS_IN ticks.
//   - acc never saturates; the carry wraps by construction.
//  Reset mid-operation: all state cleared immediately; any buffered sample is discarded.
// CONFIGURATION
//  DITHER_EN defined:
//   - a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances on each enable.
//   - Its bit0 is added as the carry-in of s; this breaks idle tones.
//   - Density stays within 2^-BITS_IN of nominal.
//  DITHER_EN undefined: carry-in is 0; the output is fully deterministic.
// STRUCTURE
//  Shared package dsp_pkg holds:
//   - typedef sample_t, signed [BITS_IN-1:0];
//   - function to_offset(sample_t), which returns the offset-binary value;
//   - localparam LFSR_SEED and LFSR_TAPS.
//  Sub-module dither_lfsr (clock, reset_n, enable, bit_out) is instantiated only under DITHER_EN.
//  Remaining logic is one always_ff block plus small combinational next-state logic.
// TESTING (BITS_IN=12, OSR_LOG2=4, enable=1 every clock, DITHER_EN off unless noted)
//  1. Reset, no samples, 16 ticks -> dac_out 0,1,0,1...; running=0; underrun never set.
//  2. Push 0 -> loaded at the first boundary, running=1; dac_out keeps 50% density (8 ones per 16 ticks).
//  3. Push -2048, then +1024 -> all zeros for one period; then exactly 12 ones per 16 ticks (u=3072), pattern 0111 repeating.
//  4. Push one sample, then stop -> underrun pulses 1 clock at each later boundary; density unchanged.
//  5. Boundary with the buffer empty and in_valid=1 in the same cycle -> direct load, underrun=0, in_ready stays 1.
//     Then hold in_valid with the buffer full -> in_ready=0 until the next boundary; no sample is lost or duplicated.
//  6. Reset_n pulse mid-period -> outputs return to reset values within the same clock.
//     Plus DITHER_EN, input +2047 over 4096 ticks -> ones count 4095±1.

Source files
------------

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared sample type, offset-binary helper and dither LFSR constants
package dsp_pkg;
    localparam int SAMPLE_W = 12;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic logic [SAMPLE_W-1:0] to_offset(input sample_t s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction
endpackage

// File: rtl/dither_lfsr.sv
// dither_lfsr: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), advances on enable; ports clock, reset_n, enable, bit_out
module dither_lfsr
    import dsp_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic bit_out
);
    logic [15:0] lfsr;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr <= LFSR_SEED;
        else if (enable) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
    assign bit_out = lfsr[0];
endmodule

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: first-order sigma-delta modulator with a 1-entry sample buffer (ports clock, reset_n, enable, in_valid/in_ready/data_in, dac_out, underrun, running; DITHER_EN adds LFSR carry-in dither)
module sigma_delta_dac
    import dsp_pkg::*;
#(
    parameter int BITS_IN  = SAMPLE_W,
    parameter int OSR_LOG2 = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [BITS_IN-1:0] data_in,
    output logic                      dac_out,
    output logic                      underrun,
    output logic                      running
);
    logic [OSR_LOG2-1:0]       tick_cnt;
    logic [BITS_IN-1:0]        acc;
    logic signed [BITS_IN-1:0] active;
    logic signed [BITS_IN-1:0] buffer;
    logic                      buf_full;
    state_t                    state, state_d;
    logic [BITS_IN-1:0]        u;
    logic [BITS_IN:0]          s;
    logic                      cin;
    logic                      boundary, accept, load_buf, load_direct, buf_full_d, underrun_d;
    if (BITS_IN == SAMPLE_W) begin : g_off
        assign u = to_offset(active);
    end else begin : g_off
        assign u = {~active[BITS_IN-1], active[BITS_IN-2:0]};
    end
`ifdef DITHER_EN
    dither_lfsr u_dither (.clock(clock), .reset_n(reset_n), .enable(enable), .bit_out(cin));
`else
    assign cin = 1'b0;
`endif
    // the carry out of s is the output bit; acc keeps only the low bits so it wraps by construction
    assign s = {1'b0, acc} + {1'b0, u} + {{BITS_IN{1'b0}}, cin};
    always_comb begin
        boundary    = enable && (&tick_cnt);
        accept      = in_valid && in_ready;
        load_buf    = boundary && buf_full;
        load_direct = boundary && !buf_full && accept;
        state_d     = (state == IDLE && (load_buf || load_direct)) ? RUN : state;
        buf_full_d  = load_buf ? 1'b0 : (accept && !boundary) ? 1'b1 : buf_full;
        underrun_d  = boundary && !buf_full && !accept && state == RUN;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            acc      <= '0;
            dac_out  <= 1'b0;
            active   <= '0;
            buffer   <= '0;
            buf_full <= 1'b0;
            in_ready <= 1'b1;
            underrun <= 1'b0;
            state    <= IDLE;
        end else begin
            if (enable) begin
                tick_cnt <= tick_cnt + 1'b1;
                acc      <= s[BITS_IN-1:0];
                dac_out  <= s[BITS_IN];
            end
            if (load_buf) active <= buffer;
            else if (load_direct) active <= data_in;
            if (accept && !boundary) buffer <= data_in;
            buf_full <= buf_full_d;
            in_ready <= !buf_full_d;
            underrun <= underrun_d;
            state    <= state_d;
        end
    end
    assign running = state == RUN;
endmodule
